// File: rtl/pulse_stretch.sv
// Turns single-cycle event strobes into level pulses of programmable width, or into toggles.
// out is registered one cycle after the strobe; overlapping events wait in a saturating counter and ovf flags each drop.
module pulse_stretch #(
  parameter int    LEN_W  = 8,
  parameter int    PEND_W = 4,
  parameter int    GAP    = 1,
  parameter string MODE   = "lvl"
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in,
  input  logic [LEN_W-1:0]  len,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam bit                IS_TGL   = (MODE == "tgl");
  localparam logic [7:0]        GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // A zero gap in level mode would merge back-to-back pulses into one.
  if ((MODE != "lvl" && MODE != "tgl") || GAP < 0 || GAP > 255 || (!IS_TGL && GAP == 0)) begin : g_bad_cfg
    $error("pulse_stretch: illegal MODE/GAP configuration");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        gcnt_q, gcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              start, from_q, enq, deq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    start   = 1'b0;
    from_q  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        from_q = (pend_q != '0);
        start  = in || from_q;
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          if (!IS_TGL) out_d = 1'b0;
          if (GAP == 0) begin
            from_q = (pend_q != '0);
            start  = in || from_q;
            if (!start) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = ST_GAP;
            gcnt_d  = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          // Only queued events may restart here; a fresh strobe on this cycle is queued.
          from_q = (pend_q != '0);
          start  = from_q;
          if (!start) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_HIGH;
      cnt_d   = (len == '0) ? '0 : len - 1'b1;
      out_d   = IS_TGL ? ~out_q : 1'b1;
      busy_d  = 1'b1;
    end

    // A strobe is consumed only by a direct start; otherwise it joins the queue.
    enq = in && !(start && !from_q);
    deq = start && from_q;
    if (enq && !deq) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!enq && deq) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three instances (lvl GAP=1, lvl GAP=2 PEND_W=2, tgl GAP=0) with pulse/toggle scoreboards.
module tb_pulse_stretch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic       resetn = 1'b0;
  logic       a_in = 1'b0, b_in = 1'b0, c_in = 1'b0;
  logic [7:0] a_len = 8'd1, b_len = 8'd1, c_len = 8'd1;
  logic       a_out, a_busy, a_ovf;
  logic       b_out, b_busy, b_ovf;
  logic       c_out, c_busy, c_ovf;
  logic [3:0] a_pend, c_pend;
  logic [1:0] b_pend;

  pulse_stretch #(.LEN_W(8), .PEND_W(4), .GAP(1), .MODE("lvl")) u_a (
    .clk(clk), .resetn(resetn), .in(a_in), .len(a_len),
    .out(a_out), .busy(a_busy), .pend(a_pend), .ovf(a_ovf));

  pulse_stretch #(.LEN_W(8), .PEND_W(2), .GAP(2), .MODE("lvl")) u_b (
    .clk(clk), .resetn(resetn), .in(b_in), .len(b_len),
    .out(b_out), .busy(b_busy), .pend(b_pend), .ovf(b_ovf));

  pulse_stretch #(.LEN_W(8), .PEND_W(4), .GAP(0), .MODE("tgl")) u_c (
    .clk(clk), .resetn(resetn), .in(c_in), .len(c_len),
    .out(c_out), .busy(c_busy), .pend(c_pend), .ovf(c_ovf));

  typedef struct {
    int rise;
    int width;
  } pulse_t;

  pulse_t a_q[$];
  pulse_t b_q[$];
  int     c_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare every completed pulse / toggle against the queued expectation.
  int   a_rise = 0, b_rise = 0, b_ovf_cnt = 0, c_tog_cnt = 0;
  logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'bx;

  always @(negedge clk) begin
    pulse_t e;
    if (a_out === 1'b1 && a_prev === 1'b0) a_rise = cyc;
    if (a_out === 1'b0 && a_prev === 1'b1) begin
      if (a_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_pulse: rise %0d width %0d, none expected", a_rise, cyc - a_rise);
      end else begin
        e = a_q.pop_front();
        chk("a_pulse_rise", a_rise, e.rise);
        chk("a_pulse_width", cyc - a_rise, e.width);
      end
    end
    a_prev = a_out;
  end

  always @(negedge clk) begin
    pulse_t e;
    if (b_ovf === 1'b1) b_ovf_cnt++;
    if (b_out === 1'b1 && b_prev === 1'b0) b_rise = cyc;
    if (b_out === 1'b0 && b_prev === 1'b1) begin
      if (b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_pulse: rise %0d width %0d, none expected", b_rise, cyc - b_rise);
      end else begin
        e = b_q.pop_front();
        chk("b_pulse_rise", b_rise, e.rise);
        chk("b_pulse_width", cyc - b_rise, e.width);
      end
    end
    b_prev = b_out;
  end

  always @(negedge clk) begin
    if ((c_prev === 1'b0 || c_prev === 1'b1) && c_out !== c_prev) begin
      c_tog_cnt++;
      if (c_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL c_unexpected_toggle: at cycle %0d, none expected", cyc);
      end else begin
        chk("c_toggle_cycle", cyc, c_q.pop_front());
      end
    end
    c_prev = c_out;
  end

  initial begin
    int t;
    int tog0;
    repeat (3) @(negedge clk);
    chk("rst_a_out", a_out, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_pend", a_pend, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_c_out", c_out, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single strobe, len=4, GAP=1.
    t = cyc; a_len = 8'd4; a_in = 1'b1;
    a_q.push_back('{t + 1, 4});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      a_in = 1'b0;
      chk("t1_out", a_out, (k <= 4));
      chk("t1_busy", a_busy, (k <= 5));
      chk("t1_pend", a_pend, 0);
      chk("t1_ovf", a_ovf, 0);
    end

    // len=0 behaves as len=1.
    t = cyc; a_len = 8'd0; a_in = 1'b1;
    a_q.push_back('{t + 1, 1});
    @(negedge clk); a_in = 1'b0;
    repeat (4) @(negedge clk);

    // len changes 3 -> 6 mid-pulse while a second event is queued.
    t = cyc; a_len = 8'd3; a_in = 1'b1;
    a_q.push_back('{t + 1, 3});
    a_q.push_back('{t + 5, 6});
    @(negedge clk); a_len = 8'd6; a_in = 1'b1;
    @(negedge clk); a_in = 1'b0;
    chk("t3_pend_queued", a_pend, 1);
    repeat (12) @(negedge clk);
    chk("t3_idle_busy", a_busy, 0);

    // Two strobes two cycles apart, len=5, GAP=2.
    t = cyc; b_len = 8'd5; b_in = 1'b1;
    b_q.push_back('{t + 1, 5});
    b_q.push_back('{t + 8, 5});
    @(negedge clk); b_in = 1'b0;
    @(negedge clk); b_in = 1'b1;
    @(negedge clk); b_in = 1'b0;
    chk("t2_pend_one", b_pend, 1);
    repeat (5) @(negedge clk);
    chk("t2_pend_zero", b_pend, 0);
    chk("t2_second_out", b_out, 1);
    repeat (10) @(negedge clk);
    chk("t2_idle_busy", b_busy, 0);

    // Saturation with PEND_W=2: five back-to-back strobes, len=10.
    t = cyc; b_len = 8'd10; b_in = 1'b1; b_ovf_cnt = 0;
    for (int i = 0; i < 4; i++) b_q.push_back('{t + 1 + 12 * i, 10});
    repeat (4) @(negedge clk);
    chk("t4_pend_sat", b_pend, 3);
    @(negedge clk); b_in = 1'b0;
    chk("t4_ovf_pulse", b_ovf, 1);
    chk("t4_pend_hold", b_pend, 3);
    @(negedge clk);
    chk("t4_ovf_clear", b_ovf, 0);
    repeat (45) @(negedge clk);
    chk("t4_ovf_count", b_ovf_cnt, 1);
    chk("t4_idle_busy", b_busy, 0);
    chk("t4_idle_pend", b_pend, 0);

    // Toggle mode, GAP=0, len=1, in held for six cycles.
    t = cyc; tog0 = c_tog_cnt; c_len = 8'd1; c_in = 1'b1;
    for (int i = 1; i <= 6; i++) c_q.push_back(t + i);
    repeat (6) @(negedge clk);
    c_in = 1'b0;
    @(negedge clk);
    chk("t5_toggles", c_tog_cnt - tog0, 6);
    chk("t5_out", c_out, 0);
    chk("t5_busy", c_busy, 0);
    chk("t5_pend", c_pend, 0);

    // Reset mid-HIGH with two queued events; toggle output also returns to 0.
    t = cyc; a_len = 8'd10; a_in = 1'b1; c_len = 8'd5; c_in = 1'b1;
    a_q.push_back('{t + 1, 3});
    c_q.push_back(t + 1);
    c_q.push_back(t + 4);
    @(negedge clk); c_in = 1'b0;
    @(negedge clk);
    @(negedge clk); a_in = 1'b0;
    chk("t6_pend_two", a_pend, 2);
    chk("t6_busy_pre", a_busy, 1);
    resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("t6_out_rst", a_out, 0);
    chk("t6_busy_rst", a_busy, 0);
    chk("t6_pend_rst", a_pend, 0);
    chk("t6_c_out_rst", c_out, 0);
    chk("t6_c_busy_rst", c_busy, 0);
    repeat (30) @(negedge clk);
    chk("t6_no_restart", a_busy, 0);
    chk("t6_no_pend", a_pend, 0);

    chk("a_missing_pulses", a_q.size(), 0);
    chk("b_missing_pulses", b_q.size(), 0);
    chk("c_missing_toggles", c_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Pulse-to-level generator. It is the transmit-side counterpart of the edge detector.
- Converts single-cycle event strobes into level pulses of programmable width, or into toggle transitions.
- Downstream edge detection, possibly in another clock domain after a synchronizer, recovers one event per output pulse or toggle.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter. None are lost until the counter is full.

Parameters:
- LEN_W, 8, width of the pulse-length input and the internal length counter.
- PEND_W, 4, width of the pending-event counter. Queue depth is 2^PEND_W-1.
- GAP, 1, minimum number of low (lvl) or stable (tgl) cycles between consecutive events. Legal range 0..255. GAP=0 is illegal when MODE="lvl"; this is checked by an elaboration assertion.
- MODE, "lvl", output encoding: "lvl" gives a high pulse per event, "tgl" gives one transition of out per event.

Ports:
- clk, input, 1, clock. All logic is on the rising edge.
- resetn, input, 1, synchronous active-low reset.
- in, input, 1, event strobe. Each high cycle is one event.
- len, input, LEN_W, pulse length in cycles. Sampled at pulse start. 0 is treated as 1.
- out, output, 1, registered stretched pulse (lvl) or toggle (tgl).
- busy, output, 1, high while in the HIGH or GAP state.
- pend, output, PEND_W, number of queued events not yet started.
- ovf, output, 1, one-cycle pulse when an event is dropped because pend is saturated.

Behaviour:

Reset:
- When resetn=0 at a clock edge: state=IDLE, out=0, busy=0, pend=0, ovf=0, counters cleared.
- Reset mid-pulse aborts immediately and discards the queue. In tgl mode, out returns to 0.

FSM states and transitions:
- IDLE → HIGH when in=1 or pend!=0. In the same edge:
  - load cnt=max(len,1)-1;
  - lvl: out<=1; tgl: out<=~out;
  - busy<=1.
- HIGH:
  - cnt decrements each cycle.
  - When cnt=0: lvl: out<=0. Then go to GAP with gcnt=GAP-1, or directly back to the start check if GAP=0 (tgl only).
- GAP:
  - gcnt decrements each cycle.
  - When gcnt=0: if pend!=0, start the next event as from IDLE, which dequeues it. Otherwise go to IDLE with busy<=0.

Timing:
- Latency: out changes on the first clock edge at which in=1 is sampled in IDLE. This is 1 cycle, registered. Out is never combinational from in.
- lvl pulse width is exactly max(len,1) cycles.
- Start-to-start spacing for queued events is max(len,1)+GAP cycles.

Queue (pend):
- in=1 while not starting (HIGH/GAP, or the GAP final cycle without a start): pend+1.
- A start from the queue: pend-1.
- in=1 in the same cycle as a start from the queue: pend unchanged. The new event is queued and the oldest is consumed.
- in=1 in IDLE with pend=0: starts directly and does not touch pend.
- Saturation: at pend=2^PEND_W-1, a further increment is dropped. ovf=1 for that cycle and pend holds.

Other rules:
- len change while busy has no effect on the current pulse. The new value applies at the next start.
- Continuous in=1: one event per cycle, queued as above. Overflow once full.
- busy=1 exactly from the first out change through the last GAP cycle.

Test Plan:
- Reset, then a single in pulse with len=4, GAP=1, lvl → out high for cycles 1..4 after the strobe, busy 1..5, pend stays 0, ovf 0.
- Two strobes 2 cycles apart, len=5, GAP=2 → pend goes to 1 and then 0 at the second start. The second out rising edge is 7 cycles after the first. Both pulses are 5 wide.
- len=0 → 1-cycle pulse. A len change 3→6 mid-pulse → current pulse 3 wide, next pulse 6 wide.
- PEND_W=2, len=10, 5 strobes during the first pulse → pend saturates at 3. Exactly 1 ovf pulse, on the 5th strobe. Total 4 output pulses.
- MODE="tgl", GAP=0, len=1, in held high for 6 cycles → out toggles every cycle, 6 transitions. Check with an edge detector of type "ed": 6 events.
- resetn=0 mid-HIGH with pend=2 → next cycle out=0, busy=0, pend=0. No further pulses.
